// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU shift path:
//   WIDTH / AMT_W  : operand width (8) and shift-amount width (3)
//   OP_*           : shift/rotate opcodes, 101-111 are illegal
//   ST_*           : shift_sequencer state encoding (3 bits)
//   isLegalOp()    : true for the five defined opcodes
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int WIDTH = 8;
   localparam int AMT_W = 3;

   localparam logic [2:0] OP_LSL = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b001;
   localparam logic [2:0] OP_ASR = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_S4   = 3'd1;
   localparam logic [2:0] ST_S2   = 3'd2;
   localparam logic [2:0] ST_S1   = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   function automatic logic isLegalOp(input logic [2:0] opCode);
      return (opCode <= OP_ROR);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
// One combinational binary shift/rotate stage of k = 4, 2 or 1 positions.
// Ports:
//   data        in  operand for this stage
//   op          in  opcode (illegal opcodes pass data through)
//   k           in  stage size (4/2/1); 0 means no stage
//   enable      in  apply the stage (amount bit for this stage is set)
//   data_out    out shifted/rotated data, or data unchanged when not applied
//   carry_out   out last bit shifted or rotated out
//   carry_valid out carry_out is meaningful (stage actually applied)
// ---------------------------------------------------------------------------
module shift_stage
   import alu_pkg::*;
(
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] k,
   input  logic             enable,
   output logic [WIDTH-1:0] data_out,
   output logic             carry_out,
   output logic             carry_valid
);

   // leftIdx = WIDTH - k (mod 8): the last bit leaving on a left shift, and
   // the back-shift distance for rotates. rightIdx = k - 1 for right shifts.
   logic [AMT_W-1:0] leftIdx;
   logic [AMT_W-1:0] rightIdx;

   assign leftIdx  = ~k + 1'b1;
   assign rightIdx = k - 1'b1;

   always_comb begin
      data_out    = data;
      carry_out   = 1'b0;
      carry_valid = 1'b0;
      if (enable && (k != '0) && isLegalOp(op)) begin
         carry_valid = 1'b1;
         case (op)
            OP_LSL: begin
               data_out  = data << k;
               carry_out = data[leftIdx];
            end
            OP_LSR: begin
               data_out  = data >> k;
               carry_out = data[rightIdx];
            end
            OP_ASR: begin
               data_out  = $signed(data) >>> k;
               carry_out = data[rightIdx];
            end
            OP_ROL: begin
               data_out  = (data << k) | (data >> leftIdx);
               carry_out = data[leftIdx];
            end
            OP_ROR: begin
               data_out  = (data >> k) | (data << leftIdx);
               carry_out = data[rightIdx];
            end
            default: begin
               data_out    = data;
               carry_valid = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle shift/rotate controller: one shift_stage reused for the
// 4-, 2- and 1-position stages in states S4, S2, S1.
// Ports:
//   clk, rst  in  clock, synchronous active-high reset
//   start     in  request, sampled only in IDLE or DONE
//   op, amt   in  opcode and 0-7 shift amount
//   din       in  8-bit operand
//   busy      out high in S4/S2/S1
//   done      out one-cycle pulse, result valid
//   dout      out result, held until the next accept
//   carry     out last bit shifted/rotated out (0 for amt=0)
//   zero      out dout == 0
//   err       out illegal opcode flag for the held result
//
// Handshake: a cycle with start=1 while in IDLE or DONE is an accept; the
// operands are latched on that edge. start in any other state is dropped,
// never queued. done rises exactly 4 cycles after a legal accept (2 for an
// illegal opcode) and lasts one cycle; start=1 during done accepts the next
// request back-to-back.
// ---------------------------------------------------------------------------
module shift_sequencer
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             carry,
   output logic             zero,
   output logic             err
);

   logic [2:0]       state;
   logic [2:0]       opReg;
   logic [AMT_W-1:0] amtReg;
   logic [WIDTH-1:0] workReg;
   logic             workCarry;

   logic [AMT_W-1:0] stageK;
   logic             stageEn;
   logic [WIDTH-1:0] stageData;
   logic             stageCarry;
   logic             stageCarryValid;

   // Stage size and enable follow the state: S4 uses amt[2], S2 amt[1],
   // S1 amt[0].
   always_comb begin
      stageK  = '0;
      stageEn = 1'b0;
      case (state)
         ST_S4: begin
            stageK  = 3'd4;
            stageEn = amtReg[2];
         end
         ST_S2: begin
            stageK  = 3'd2;
            stageEn = amtReg[1];
         end
         ST_S1: begin
            stageK  = 3'd1;
            stageEn = amtReg[0];
         end
         default: begin
            stageK  = '0;
            stageEn = 1'b0;
         end
      endcase
   end

   shift_stage uStage (
      .data        (workReg),
      .op          (opReg),
      .k           (stageK),
      .enable      (stageEn),
      .data_out    (stageData),
      .carry_out   (stageCarry),
      .carry_valid (stageCarryValid)
   );

   assign busy = (state == ST_S4) || (state == ST_S2) || (state == ST_S1);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         opReg     <= '0;
         amtReg    <= '0;
         workReg   <= '0;
         workCarry <= 1'b0;
         dout      <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  opReg     <= op;
                  amtReg    <= amt;
                  workReg   <= din;
                  workCarry <= 1'b0;
                  carry     <= 1'b0;
                  err       <= 1'b0;
                  state     <= ST_S4;
                  // Illegal opcodes publish the operand unchanged right away;
                  // S4 then routes straight to DONE without running a stage.
                  if (!isLegalOp(op)) begin
                     dout <= din;
                     zero <= (din == '0);
                     err  <= 1'b1;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_S4: begin
               if (!isLegalOp(opReg)) begin
                  state <= ST_DONE;
               end else begin
                  workReg <= stageData;
                  if (stageCarryValid) workCarry <= stageCarry;
                  state <= ST_S2;
               end
            end
            ST_S2: begin
               workReg <= stageData;
               if (stageCarryValid) workCarry <= stageCarry;
               state <= ST_S1;
            end
            ST_S1: begin
               workReg <= stageData;
               dout    <= stageData;
               carry   <= stageCarryValid ? stageCarry : workCarry;
               zero    <= (stageData == '0);
               state   <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
// Self-checking bench for shift_sequencer. Expected {err, zero, carry, dout}
// words go into expQ when a request is driven and are popped on done.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] op;
   logic [2:0] amt;
   logic [7:0] din;
   logic       busy;
   logic       done;
   logic [7:0] dout;
   logic       carry;
   logic       zero;
   logic       err;

   logic [10:0] expQ[$];
   int assertCount = 0;
   int failCount   = 0;

   shift_sequencer dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .amt   (amt),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .carry (carry),
      .zero  (zero),
      .err   (err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: bit-serial shift, one position per iteration.
   function automatic logic [10:0] model(input logic [2:0] o, input logic [2:0] a,
                                         input logic [7:0] d);
      logic [7:0] w;
      logic       c;
      w = d;
      c = 1'b0;
      if (o > 3'd4) return {1'b1, (d == 8'd0), 1'b0, d};
      for (int i = 0; i < int'(a); i++) begin
         case (o)
            3'd0: begin c = w[7]; w = {w[6:0], 1'b0}; end
            3'd1: begin c = w[0]; w = {1'b0, w[7:1]}; end
            3'd2: begin c = w[0]; w = {w[7], w[7:1]}; end
            3'd3: begin c = w[7]; w = {w[6:0], w[7]}; end
            default: begin c = w[0]; w = {w[0], w[7:1]}; end
         endcase
      end
      return {1'b0, (w == 8'd0), c, w};
   endfunction

   // driver: single request, wait for done, check result and hold
   task automatic runOp(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d,
                        input logic [10:0] expWord, input int expLat, input string name);
      int lat;
      logic [10:0] want;
      logic [10:0] got;
      expQ.push_back(expWord);
      @(negedge clk);
      op = o; amt = a; din = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op  = 3'($urandom_range(0, 7));
      amt = 3'($urandom_range(0, 7));
      din = 8'($urandom_range(0, 255));
      lat = 1;
      assertCount++;
      if (busy !== 1'b1) begin
         failCount++;
         $display("FAIL %s busy: got %b want 1", name, busy);
      end
      while (done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      assertCount++;
      if (lat !== expLat) begin
         failCount++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, expLat);
      end
      want = (expQ.size() > 0) ? expQ.pop_front() : 11'h7FF;
      got  = {err, zero, carry, dout};
      assertCount++;
      if (got !== want) begin
         failCount++;
         $display("FAIL %s result {err,zero,carry,dout}: got %h want %h", name, got, want);
      end
      @(negedge clk);
      got = {err, zero, carry, dout};
      assertCount++;
      if (done !== 1'b0 || got !== want) begin
         failCount++;
         $display("FAIL %s hold: done=%b got %h want done=0 %h", name, done, got, want);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = '0; amt = '0; din = '0;
      repeat (3) @(negedge clk);
      assertCount++;
      if ({busy, done, err, zero, carry, dout} !== 13'd0) begin
         failCount++;
         $display("FAIL reset outputs: got %h want 0", {busy, done, err, zero, carry, dout});
      end
      rst = 1'b0;
      @(negedge clk);
      assertCount++;
      if ({busy, done} !== 2'b00) begin
         failCount++;
         $display("FAIL reset idle: busy/done got %b want 00", {busy, done});
      end
   endtask

   task automatic test_directed();
      runOp(OP_LSL, 3'd1, 8'h81, {1'b0, 1'b0, 1'b1, 8'h02}, 4, "lsl_81_1");
      runOp(OP_ASR, 3'd3, 8'h90, {1'b0, 1'b0, 1'b0, 8'hF2}, 4, "asr_90_3");
      runOp(OP_LSR, 3'd4, 8'h0F, {1'b0, 1'b1, 1'b1, 8'h00}, 4, "lsr_0f_4");
      runOp(OP_ROR, 3'd7, 8'h01, {1'b0, 1'b0, 1'b0, 8'h02}, 4, "ror_01_7");
      runOp(OP_ROL, 3'd1, 8'h81, {1'b0, 1'b0, 1'b1, 8'h03}, 4, "rol_81_1");
      runOp(OP_LSL, 3'd0, 8'h5A, {1'b0, 1'b0, 1'b0, 8'h5A}, 4, "amt0_5a");
      runOp(OP_ROL, 3'd7, 8'h80, {1'b0, 1'b0, 1'b0, 8'h40}, 4, "rol_80_7");
   endtask

   task automatic test_random();
      logic [2:0] o;
      logic [2:0] a;
      logic [7:0] d;
      for (int i = 0; i < 20; i++) begin
         o = 3'($urandom_range(0, 4));
         a = 3'($urandom_range(0, 7));
         d = 8'($urandom_range(0, 255));
         runOp(o, a, d, model(o, a, d), 4, "random");
      end
   endtask

   task automatic test_illegal();
      runOp(3'b110, 3'd2, 8'h33, {1'b1, 1'b0, 1'b0, 8'h33}, 2, "illegal_110");
      runOp(OP_LSL, 3'd1, 8'h81, {1'b0, 1'b0, 1'b1, 8'h02}, 4, "err_clear");
      runOp(3'b111, 3'd5, 8'h00, {1'b1, 1'b1, 1'b0, 8'h00}, 2, "illegal_111_zero");
   endtask

   task automatic test_ignore_start();
      int lat;
      logic [10:0] want;
      logic [10:0] got;
      int extraDone;
      expQ.push_back({1'b0, 1'b0, 1'b1, 8'h02});
      @(negedge clk);
      op = OP_LSL; amt = 3'd1; din = 8'h81; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      @(negedge clk);
      lat = 2;
      // state S2: stray request with different operands
      start = 1'b1; op = OP_ROR; amt = 3'd7; din = 8'hFF;
      @(negedge clk);
      lat = 3;
      start = 1'b0;
      while (done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      assertCount++;
      if (lat !== 4) begin
         failCount++;
         $display("FAIL ignore_start latency: got %0d want 4", lat);
      end
      want = (expQ.size() > 0) ? expQ.pop_front() : 11'h7FF;
      got  = {err, zero, carry, dout};
      assertCount++;
      if (got !== want) begin
         failCount++;
         $display("FAIL ignore_start result: got %h want %h", got, want);
      end
      extraDone = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) extraDone++;
      end
      assertCount++;
      if (extraDone !== 0) begin
         failCount++;
         $display("FAIL ignore_start queued: extra done pulses got %0d want 0", extraDone);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [10:0] want;
      logic [10:0] got;
      expQ.push_back({1'b0, 1'b0, 1'b1, 8'h03});
      @(negedge clk);
      op = OP_ROL; amt = 3'd1; din = 8'h81; start = 1'b1;
      lat = 0;
      while (done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      assertCount++;
      if (lat !== 4) begin
         failCount++;
         $display("FAIL b2b first latency: got %0d want 4", lat);
      end
      want = (expQ.size() > 0) ? expQ.pop_front() : 11'h7FF;
      got  = {err, zero, carry, dout};
      assertCount++;
      if (got !== want) begin
         failCount++;
         $display("FAIL b2b first result: got %h want %h", got, want);
      end
      // start still high through DONE: second request accepted on this edge
      expQ.push_back({1'b0, 1'b1, 1'b1, 8'h00});
      op = OP_LSR; amt = 3'd4; din = 8'h0F;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      assertCount++;
      if (lat !== 4) begin
         failCount++;
         $display("FAIL b2b second latency: got %0d want 4", lat);
      end
      want = (expQ.size() > 0) ? expQ.pop_front() : 11'h7FF;
      got  = {err, zero, carry, dout};
      assertCount++;
      if (got !== want) begin
         failCount++;
         $display("FAIL b2b second result: got %h want %h", got, want);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int sawDone;
      @(negedge clk);
      op = OP_LSL; amt = 3'd1; din = 8'h81; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      assertCount++;
      if ({busy, done, err, zero, carry, dout} !== 13'd0) begin
         failCount++;
         $display("FAIL reset_mid outputs: got %h want 0", {busy, done, err, zero, carry, dout});
      end
      rst = 1'b0;
      sawDone = 0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) sawDone++;
      end
      assertCount++;
      if (sawDone !== 0) begin
         failCount++;
         $display("FAIL reset_mid done pulses: got %0d want 0", sawDone);
      end
      runOp(OP_ASR, 3'd3, 8'h90, {1'b0, 1'b0, 1'b0, 8'hF2}, 4, "after_reset");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_illegal();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
